// File: rtl/lumos_boot_pkg.sv
// Shared types for the boot loader: receiver and loader state encodings
// plus the image header length.
package lumos_boot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        HDR_LO,
        HDR_HI,
        WORDS,
        DONE
    } ld_state_t;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid on a good stop bit and stop_err on a bad one.
module uart_rx_byte
    import lumos_boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    rx_state_t     r_state;
    rx_state_t     w_next;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          r_err;
    logic          w_half;
    logic          w_full;

    assign w_half = (r_baud == CW'(CLKS_PER_BIT / 2 - 1));
    assign w_full = (r_baud == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (!r_sync2) w_next = START;
            START: if (w_half) w_next = r_sync2 ? IDLE : DATA;
            DATA:  if (w_full && r_bit == 3'd7) w_next = STOP;
            STOP:  if (w_full) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            // Baud counter restarts on every state change and after each data sample.
            if (r_state != w_next || (r_state == DATA && w_full)) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_state == DATA && w_full) begin
                r_shift <= {r_sync2, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
            r_valid <= (r_state == STOP) && w_full && r_sync2;
            r_err   <= (r_state == STOP) && w_full && !r_sync2;
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_shift;
    assign stop_err   = r_err;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: parses a little-endian word-count header and word stream from
// the UART, writes instruction memory and releases the core once complete.
module imem_uart_loader
    import lumos_boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int IMEM_AW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               core_rst,
    output logic               load_done,
    output logic               frame_err
);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_stop_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .stop_err   (w_stop_err)
    );

    ld_state_t          r_state;
    ld_state_t          w_next;
    logic [15:0]        r_count;
    logic [31:0]        r_word;
    logic [1:0]         r_bcnt;
    logic [15:0]        r_widx;
    logic               r_we;
    logic [IMEM_AW-1:0] r_addr;
    logic [31:0]        r_wdata;
    logic               r_last_we;
    logic               r_done;
    logic               r_ferr;
    logic [15:0]        w_count_hi;
    logic [31:0]        w_full_word;
    logic               w_last;
    logic               w_in_range;

    assign w_count_hi  = {w_byte_data, r_count[7:0]};
    assign w_full_word = {w_byte_data, r_word[31:8]};
    assign w_last      = ((r_widx + 16'd1) == r_count);
    assign w_in_range  = ((r_widx >> IMEM_AW) == 16'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            HDR_LO: if (w_byte_valid) w_next = HDR_HI;
            HDR_HI: if (w_byte_valid) w_next = (w_count_hi == 16'd0) ? DONE : WORDS;
            WORDS:  if (w_byte_valid && r_bcnt == 2'd3 && w_last) w_next = DONE;
            DONE:   w_next = DONE;
            default: w_next = HDR_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HDR_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_word    <= '0;
            r_bcnt    <= '0;
            r_widx    <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_last_we <= 1'b0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_last_we <= 1'b0;
            if (w_stop_err) r_ferr <= 1'b1;
            // Release the core only after the final write has been presented.
            if (r_last_we) r_done <= 1'b1;
            case (r_state)
                HDR_LO: if (w_byte_valid) r_count[7:0] <= w_byte_data;
                HDR_HI: begin
                    if (w_byte_valid) begin
                        r_count[15:8] <= w_byte_data;
                        if (w_count_hi == 16'd0) r_done <= 1'b1;
                    end
                end
                WORDS: begin
                    if (w_byte_valid) begin
                        r_word <= w_full_word;
                        r_bcnt <= r_bcnt + 1'b1;
                        if (r_bcnt == 2'd3) begin
                            r_bcnt <= 2'd0;
                            r_widx <= r_widx + 16'd1;
                            if (w_in_range) begin
                                r_we    <= 1'b1;
                                r_addr  <= r_widx[IMEM_AW-1:0];
                                r_wdata <= w_full_word;
                            end
                            if (w_last) begin
                                if (w_in_range) r_last_we <= 1'b1;
                                else            r_done    <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_rst   = ~r_done;
    assign load_done  = r_done;
    assign frame_err  = r_ferr;

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Boot-time program loader for the pipelined RV32I core. It receives a program image over a serial 8N1 line and writes it word by word into instruction memory. The core is held in reset until the image is complete. It replaces the hard-coded instruction-memory init with a real loading path, and is instantiated alongside the core in the top level.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be ≥4 and even.
- IMEM_AW, 8: instruction-memory word-address width. Depth is 2^IMEM_AW words.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial input. Idle high, 8N1, LSB first.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  IMEM_AW  word address of the current write.
- imem_wdata  out  32  word being written.
- core_rst  out  1  reset to the core. High until the load completes.
- load_done  out  1  high once the image is fully loaded.
- frame_err  out  1  sticky; set on any stop-bit error.

## Operation
- **Reset values (all outputs):** core_rst=1, load_done=0, imem_we=0, imem_addr=0, imem_wdata=0, frame_err=0.
- **Input synchronizer:** rx passes through a 2-flop synchronizer; both flops reset to 1.
- **Byte receiver FSM:**
  - IDLE: wait for synchronized rx=0, then go to START.
  - START: after CLKS_PER_BIT/2 cycles, resample. If rx is still 0, go to DATA. If rx=1 (glitch), return to IDLE.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles, LSB first.
  - STOP: sample once after CLKS_PER_BIT cycles.
    - rx=1: byte accepted and byte_valid pulses for one cycle.
    - rx=0: byte discarded and frame_err set.
    - Either way, return to IDLE.
- **Image format:**
  - 16-bit word count N, little-endian (low byte first).
  - Followed by 4·N bytes; each word is little-endian (first byte goes to [7:0]).
- **Loader FSM:**
  - HDR_LO: capture count[7:0], go to HDR_HI.
  - HDR_HI: capture count[15:8]. If N=0, go to DONE; otherwise go to WORDS.
  - WORDS:
    - Shift each byte into the word buffer and advance a 2-bit byte counter.
    - On the 4th byte, issue a write, increment the 16-bit word index, and clear the byte counter.
    - Word indices ≥2^IMEM_AW are consumed but not written; imem_we stays 0 for them.
    - When the word index reaches N, go to DONE.
  - DONE: core_rst=0, load_done=1. Further bytes are ignored. The loader leaves DONE only on rst.
- **Frame errors:** a framing-error byte does not advance the loader. frame_err stays set until rst.
- **Reset mid-load:**
  - All state returns to HDR_LO.
  - A partial word is discarded.
  - core_rst is reasserted.
  - Instruction-memory contents are not cleared.

## Timing
- byte_valid asserts the cycle after the stop-bit sample.
- imem_we, imem_addr and imem_wdata are registered outputs. They are valid together in the cycle after the 4th byte_valid.
- imem_addr and imem_wdata hold their last value when imem_we=0.
- core_rst falls, and load_done rises, in the cycle after the final imem_we. The core's first fetch therefore sees the complete image.
- With N=0, core_rst falls in the cycle after the HDR_HI byte_valid.
- If the final word index is ≥2^IMEM_AW (so no write is issued), core_rst falls in the cycle after that word's 4th byte_valid.
- The receiver accepts back-to-back frames: a new start bit may begin in the cycle after the STOP sample.

## Structure
- **Shared package lumos_boot_pkg** holds:
  - the receiver-state enum (IDLE, START, DATA, STOP);
  - the loader-state enum (HDR_LO, HDR_HI, WORDS, DONE);
  - the constant HDR_BYTES=2.
- **Sub-module uart_rx_byte (CLKS_PER_BIT):**
  - Contains the synchronizer, bit counter, baud counter and receiver FSM.
  - Outputs byte_valid, byte_data[7:0] and stop_err.
- **Top of imem_uart_loader:** contains the loader FSM, word buffer, word index, and the core_rst/load_done logic.

## Test plan
1. **Reset check:** assert rst for 3 cycles, then release with rx=1. Require core_rst=1, load_done=0, imem_we=0, frame_err=0 and imem_addr=0 for 100 cycles.
2. **Normal load:** send 02 00 13 00 00 00 93 00 10 00. Require:
   - a write to addr0 with data 0x00000013;
   - a write to addr1 with data 0x00100093;
   - core_rst=0 and load_done=1 exactly one cycle after the second imem_we.
3. **Empty image:** send header 00 00. Require no imem_we, and core_rst falls one cycle after the second byte.
4. **Framing error:** header 01 00, then a byte with stop bit 0, then 78 56 34 12. Require:
   - frame_err=1;
   - exactly one write, addr0=0x12345678;
   - load_done=1 afterwards.
5. **Start-bit glitch:** pulse rx low for CLKS_PER_BIT/4 cycles. Require no byte_valid and no state change. A following valid image loads normally.
6. **Reset mid-load:** header 02 00 then bytes AA BB, then pulse rst. Resend the full image from test 2. Require writes at addr0 and addr1 only, and the data must not contain AA or BB. After DONE, send 5 more bytes and require no further imem_we.
